// File: rtl/handshake_master.sv
// Upstream feeder: a small FIFO drained through a registered valid/data_out stage.
// Holds each presented word until the downstream stage samples ready.
module handshake_master #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DW-1:0]              wr_data,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       valid,
    input  logic                       ready,
    output logic [DW-1:0]              data_out,
    output logic [CW-1:0]              xfer_cnt,
    output logic                       ovf_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [CW-1:0] xfer_q, xfer_d;
    logic          ovf_q, ovf_d;

    logic push;
    logic load;
    logic xfer;

    assign full = (level_q == LW'(DEPTH));
    assign push = wr_en && !full;
    assign load = (!valid_q || ready) && (level_q != '0);
    assign xfer = valid_q && ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        valid_d  = valid_q;
        data_d   = data_q;
        xfer_d   = xfer_q;
        ovf_d    = ovf_q;
        level_d  = level_q + LW'(push) - LW'(load);

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (wr_en && full) begin
            ovf_d = 1'b1;
        end

        // A pending load refills the output register in the same edge it is accepted.
        if (load) begin
            data_d   = mem[rd_ptr_q];
            valid_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else if (xfer) begin
            valid_d = 1'b0;
        end

        if (xfer) begin
            xfer_d = xfer_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            xfer_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            xfer_q   <= xfer_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: the pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign level    = level_q;
    assign valid    = valid_q;
    assign data_out = data_q;
    assign xfer_cnt = xfer_q;
    assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_handshake_master.sv
// Directed bench for handshake_master (DEPTH=4, CW=4 so counter wrap is reachable quickly).
module tb_handshake_master;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic [LW-1:0] level;
    logic          valid;
    logic          ready;
    logic [DW-1:0] data_out;
    logic [CW-1:0] xfer_cnt;
    logic          ovf_err;

    int tests;
    int fails;
    int wr_idx;
    int rd_idx;
    int cyc;
    logic          pv;
    logic          pr;
    logic [DW-1:0] pd;

    handshake_master #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .level    (level),
        .valid    (valid),
        .ready    (ready),
        .data_out (data_out),
        .xfer_cnt (xfer_cnt),
        .ovf_err  (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        ready   = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        ready = 1'b1;
        wr_en = 1'b0;
        for (int n = 0; n < 50 && valid; n++) tick();
        check("drain_done", valid, 0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        wr_en = 1'b0;
        wr_data = '0;
        ready = 1'b0;
        #1;
        check("rst_valid", valid, 0);
        check("rst_data", data_out, 0);
        check("rst_level", level, 0);
        check("rst_full", full, 0);
        check("rst_xfer", xfer_cnt, 0);
        check("rst_ovf", ovf_err, 0);
        tick();
        rst_n = 1'b1;

        // Single word, stalled then accepted
        wr_en = 1'b1; wr_data = 32'hA5A5_0001;
        tick();
        wr_en = 1'b0;
        check("t1_level_e1", level, 1);
        check("t1_valid_e1", valid, 0);
        tick();
        check("t1_valid_e2", valid, 1);
        check("t1_data_e2", data_out, 32'hA5A5_0001);
        check("t1_level_e2", level, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_hold_valid", valid, 1);
            check("t1_hold_data", data_out, 32'hA5A5_0001);
        end
        ready = 1'b1;
        tick();
        check("t1_valid_done", valid, 0);
        check("t1_xfer", xfer_cnt, 1);
        check("t1_data_kept", data_out, 32'hA5A5_0001);

        // Fill and overflow
        do_reset();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 32'h10 + i;
            tick();
            if (i == 4) check("t2_full_e5", full, 1);
        end
        wr_en = 1'b0;
        check("t2_valid", valid, 1);
        check("t2_data", data_out, 32'h10);
        check("t2_level", level, 4);
        check("t2_full", full, 1);
        check("t2_ovf", ovf_err, 1);
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t2_stream_valid", valid, 1);
            check("t2_stream_data", data_out, 32'h10 + i);
        end
        tick();
        check("t2_xfer", xfer_cnt, 5);
        check("t2_level_end", level, 0);
        check("t2_valid_end", valid, 0);
        check("t2_ovf_kept", ovf_err, 1);

        // Streaming, one word per cycle
        do_reset();
        ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            wr_en   = (k <= 8);
            wr_data = 32'h100 + k - 1;
            tick();
            check("t3_level_max", level <= 1, 1);
            if (k >= 2 && k <= 9) begin
                check("t3_valid", valid, 1);
                check("t3_data", data_out, 32'h100 + k - 2);
            end
        end
        check("t3_valid_end", valid, 0);
        check("t3_xfer", xfer_cnt, 8);

        // Random ready stall with scoreboard
        do_reset();
        wr_idx = 0;
        rd_idx = 0;
        cyc = 0;
        while (rd_idx < 64 && cyc < 3000) begin
            pv = valid;
            pd = data_out;
            ready = 1'($urandom_range(0, 1));
            pr = ready;
            wr_en = (wr_idx < 64) && !full;
            wr_data = 32'h2000 + wr_idx;
            if (wr_en) wr_idx++;
            tick();
            cyc++;
            if (pv && !pr) begin
                check("t4_stall_valid", valid, 1);
                check("t4_stall_data", data_out, pd);
            end else if (pv && pr) begin
                check("t4_order", pd, 32'h2000 + rd_idx);
                rd_idx++;
            end
        end
        wr_en = 1'b0;
        ready = 1'b0;
        check("t4_count", rd_idx, 64);
        check("t4_ovf", ovf_err, 0);
        check("t4_xfer_mod16", xfer_cnt, 0);
        check("t4_valid_end", valid, 0);

        // Counter wrap, then reset with words buffered
        do_reset();
        ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            wr_en = 1'b1; wr_data = 32'h500 + i;
            tick();
        end
        drain();
        check("t5_xfer_14", xfer_cnt, 14);
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 32'h600 + i;
            tick();
        end
        drain();
        check("t5_xfer_wrap", xfer_cnt, 1);

        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 32'h3000 + i;
            tick();
        end
        wr_en = 1'b1;
        tick();
        tick();
        tick();
        wr_en = 1'b0;
        check("t5_pre_valid", valid, 1);
        check("t5_pre_data", data_out, 32'h3000);
        check("t5_pre_ovf", ovf_err, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", valid, 0);
        check("t5_rst_data", data_out, 0);
        check("t5_rst_level", level, 0);
        check("t5_rst_full", full, 0);
        check("t5_rst_xfer", xfer_cnt, 0);
        check("t5_rst_ovf", ovf_err, 0);
        #2;
        rst_n = 1'b1;
        wr_en = 1'b1; wr_data = 32'h4000;
        tick();
        wr_en = 1'b0;
        tick();
        check("t5_first_valid", valid, 1);
        check("t5_first_data", data_out, 32'h4000);
        ready = 1'b1;
        tick();
        check("t5_after_valid", valid, 0);
        check("t5_after_xfer", xfer_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/handshake_master.md
Name: handshake_master

Overview:
- Upstream feeder for the valid/ready slave stage.
- A local producer pushes words into a small internal FIFO.
- The block presents FIFO words one at a time on a registered valid/data_out interface and holds each word until the downstream stage accepts it with ready.
- It also reports FIFO level, overflow and a running count of completed transfers.

Parameters:
- DW, 32, data width of wr_data and data_out.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CW, 16, width of xfer_cnt.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- wr_en  input  1  producer write strobe.
- wr_data  input  DW  producer write data.
- full  output  1  FIFO holds DEPTH words; combinational from the level register.
- level  output  $clog2(DEPTH)+1  FIFO occupancy, excluding the output register.
- valid  output  1  data_out holds a word for downstream (registered).
- ready  input  1  downstream accept.
- data_out  output  DW  word presented downstream (registered).
- xfer_cnt  output  CW  number of completed handshakes (valid && ready at a rising edge).
- ovf_err  output  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (asynchronous, immediate) sets:
  - valid=0, data_out=0, level=0, full=0, xfer_cnt=0, ovf_err=0.
  - FIFO read and write pointers to 0.
  - Reset mid-operation discards all buffered words and the word currently held on data_out.
- Write:
  - At a rising edge with wr_en=1 and full=0, wr_data is stored at the write pointer and the write pointer increments, wrapping at DEPTH.
  - wr_en=1 with full=1 is ignored; data is unchanged and ovf_err is set to 1 and held until reset.
  - full is evaluated before the edge, so a write while full is ignored even if a pop happens in the same cycle.
- Output stage:
  - load = (!valid || ready) && (level != 0).
  - On load, data_out takes the FIFO head, valid=1 and the read pointer increments (wrapping).
  - If (valid && ready) and level==0, valid goes to 0 and data_out holds its last value.
  - Otherwise valid and data_out are unchanged.
- Handshake rules:
  - Once valid=1, valid and data_out stay stable until a rising edge samples ready=1.
  - valid never depends combinationally on ready.
  - ready=1 while valid=0 has no effect.
  - Back-to-back transfers: with ready held at 1 and the FIFO non-empty, one word transfers every cycle.
- Latency:
  - A write sampled at edge N into an empty FIFO, with valid=0, produces valid=1 after edge N+1.
  - There is no fall-through bypass.
- Level:
  - level_next = level + push - pop.
  - push = wr_en && !full; pop = load.
  - A simultaneous push and pop leaves level unchanged.
  - A write into an empty FIFO in the same cycle the output register drains does not pop, because level is 0 before the edge.
- Capacity: total buffering is DEPTH+1 words (FIFO plus output register).
- xfer_cnt: increments by 1 at every edge with valid && ready; wraps from 2^CW-1 to 0.
- Ordering: words leave in exactly the order they were accepted. Dropped overflow words never appear.

Test Plan:
- Single word:
  - Stimulus: reset, then write 0xA5A5_0001 at edge 1, ready=0.
  - Required: level=1 after edge 1; valid=1, data_out=0xA5A5_0001, level=0 after edge 2.
  - Then hold ready=0 for 5 cycles: valid and data stay stable. Raise ready: valid=0 next edge, xfer_cnt=1.
- Fill and overflow (DEPTH=4, ready=0):
  - Stimulus: write 6 words 0x10..0x15 on consecutive edges.
  - Required: output register holds 0x10; FIFO holds 0x11..0x14; full=1; 0x15 dropped; ovf_err=1.
  - Then ready=1 continuously: outputs 0x10..0x14 on consecutive cycles, xfer_cnt=5, level=0, valid=0, ovf_err still 1.
- Streaming:
  - Stimulus: ready=1, write 0x100..0x107 every cycle.
  - Required: data_out sequence 0x100..0x107 with valid continuously high from the 2nd edge; level never exceeds 1; xfer_cnt=8.
- Random ready stall:
  - Stimulus: 64 sequential words, ready toggled pseudo-randomly.
  - Required: in-order delivery with no duplicates or losses; valid/data never change while valid && !ready.
- Wrap and reset:
  - Stimulus: preload xfer_cnt to 0xFFFE via 0xFFFE transfers (or CW=4 build, 14 transfers); do 3 more transfers.
  - Required: xfer_cnt reaches 0x0001 (wrapped).
  - Then assert rst_n=0 mid-stall with 3 words buffered: all outputs return to 0 immediately, and after release the first new write is the first word out.
